pc_gen: RTL and testbench
=========================

// Module: pc_gen
// PURPOSE
//  Parametrised program-counter generator; next generation of the core PC stage.
//  Presents the fetch address to the IF stage over a valid/ready handshake.
//  Selects the next PC from three sources, highest priority first: EX flush, branch prediction, sequential.
//  Holds a late prediction in a pending slot until the fetch is accepted, and delays the first fetch after reset.
// PARAMETERS
//  XLEN        32      address width in bits
//  RESET_ADDR  32'h0   pc_o value at reset (XLEN bits)
//  INST_BYTES  4       sequential increment; power of 2, 2 or 4; low log2(INST_BYTES) target bits are cleared
//  BOOT_DELAY  2       cycles after reset release before fetch_valid_o may assert; 0 = none, max 255
// PORTS
//  clk            in   1     clock
//  rstn           in   1     async reset, active-low
//  hold_i         in   1     pipeline hold from ctrl; blocks the handshake
//  flush_en_i     in   1     EX redirect (mispredict or jump)
//  flush_base_i   in   XLEN  EX redirect base
//  flush_ofset_i  in   XLEN  EX redirect offset
//  prd_en_i       in   1     predictor taken for the PC currently on pc_o
//  prd_base_i     in   XLEN  predicted target base
//  prd_ofset_i    in   XLEN  predicted target offset
//  fetch_ready_i  in   1     IF can accept the address
//  fetch_valid_o  out  1     pc_o is a valid fetch request
//  pc_o           out  XLEN  current fetch address
//  pend_o         out  1     prediction target held in the pending slot
// BEHAVIOUR
//  Reset (async, rstn=0):
//   - pc_o=RESET_ADDR, fetch_valid_o=0, pend_o=0, pend_tgt=0, boot_cnt=0.
//   - state=BOOT, or RUN when BOOT_DELAY==0.
//   - A reset mid-operation discards any pending target.
//  Targets:
//   - tgt = (base+ofset) mod 2^XLEN; carry is dropped.
//   - Low log2(INST_BYTES) bits are forced to 0.
//   - Sequential next = pc_o+INST_BYTES, wrapping at 2^XLEN.
//  FSM:
//   - BOOT: boot_cnt increments each cycle.
//   - BOOT -> RUN when boot_cnt==BOOT_DELAY-1.
//   - RUN persists until reset.
//  fetch_valid_o = (state==RUN) & ~hold_i. Combinational from state and hold_i only; never from ready.
//  Handshake: hs = fetch_valid_o & fetch_ready_i.
//  Next-PC rules, evaluated in order; registered with 1-cycle latency:
//   1. flush_en_i:
//      - pc_o <= flush tgt; pend cleared.
//      - Applies in any state, and regardless of hold_i or ready.
//      - A simultaneous prd_en_i is dropped.
//   2. hs & prd_en_i: pc_o <= prd tgt; pend cleared. A live prediction overrides a stale pend.
//   3. hs & pend_o: pc_o <= pend_tgt; pend cleared.
//   4. hs: pc_o <= pc_o+INST_BYTES.
//   5. ~hs & prd_en_i & state==RUN:
//      - pend_tgt <= prd tgt; pend_o <= 1; pc_o held.
//      - A newer prediction overwrites the older one.
//   6. Otherwise everything holds.
//  Additional rules:
//   - prd_en_i during BOOT is ignored.
//   - A flush during BOOT updates pc_o; the boot count is unaffected.
//   - pc_o is stable while fetch_valid_o=1 and ready=0, except on a flush.
//   - pend_o is a registered output.
// TESTING
//  1. Reset, BOOT_DELAY=2, ready=1 -> valid=0 for 2 cycles; then pc_o 0x0,0x4,0x8 on successive cycles.
//  2. pc_o=0x10, prd_en base=0x100 ofset=0x20, ready=1 -> next pc_o=0x120, pend_o=0.
//  3. pc_o=0x10, ready=0, prd tgt 0x200 -> pend_o=1 and pc_o stays 0x10; ready=1 next -> pc_o=0x200, pend_o=0.
//  4. flush base=0x80 ofset=0x6 with hold_i=1 and pend_o=1 -> pc_o=0x84 (low bits cleared), pend_o=0, valid=0 while held.
//  5. pc_o=0xFFFFFFFC, hs -> pc_o=0x0; flush base=0xFFFFFFF0 ofset=0x20 -> pc_o=0x10.
//  6. Assert rstn=0 mid-run with pend_o=1 -> pc_o=RESET_ADDR, pend_o=0 immediately; BOOT repeats.

Source files
------------

// File: rtl/pc_gen.sv
// Program-counter generator: picks flush, prediction or sequential next PC
// and offers it to IF over a valid/ready handshake, with a boot delay.
module pc_gen #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_ADDR = '0,
  parameter int              INST_BYTES = 4,
  parameter int              BOOT_DELAY = 2
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            hold_i,
  input  logic            flush_en_i,
  input  logic [XLEN-1:0] flush_base_i,
  input  logic [XLEN-1:0] flush_ofset_i,
  input  logic            prd_en_i,
  input  logic [XLEN-1:0] prd_base_i,
  input  logic [XLEN-1:0] prd_ofset_i,
  input  logic            fetch_ready_i,
  output logic            fetch_valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic            pend_o
);

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [XLEN-1:0] LOW_MASK = XLEN'(INST_BYTES - 1);
  localparam logic [XLEN-1:0] STEP     = XLEN'(INST_BYTES);
  localparam logic [7:0]      BOOT_LAST = 8'(BOOT_DELAY - 1);
  localparam state_e RST_STATE = (BOOT_DELAY == 0) ? RUN : BOOT;

  state_e          state_q, state_d;
  logic [7:0]      boot_cnt_q, boot_cnt_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;
  logic            pend_q, pend_d;
  logic [XLEN-1:0] flush_tgt, prd_tgt;
  logic            hs;

  always_comb begin
    flush_tgt = (flush_base_i + flush_ofset_i) & ~LOW_MASK;
    prd_tgt   = (prd_base_i + prd_ofset_i) & ~LOW_MASK;
    fetch_valid_o = (state_q == RUN) & ~hold_i;
    hs = fetch_valid_o & fetch_ready_i;

    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    if (state_q == BOOT) begin
      boot_cnt_d = boot_cnt_q + 8'd1;
      if (boot_cnt_q == BOOT_LAST) state_d = RUN;
    end

    pc_d       = pc_q;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    // A live prediction wins over a stale pending one on the same handshake
    if (flush_en_i) begin
      pc_d   = flush_tgt;
      pend_d = 1'b0;
    end else if (hs && prd_en_i) begin
      pc_d   = prd_tgt;
      pend_d = 1'b0;
    end else if (hs && pend_q) begin
      pc_d   = pend_tgt_q;
      pend_d = 1'b0;
    end else if (hs) begin
      pc_d = pc_q + STEP;
    end else if (prd_en_i && state_q == RUN) begin
      pend_tgt_d = prd_tgt;
      pend_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= RST_STATE;
      boot_cnt_q <= '0;
      pc_q       <= RESET_ADDR;
      pend_tgt_q <= '0;
      pend_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      pc_q       <= pc_d;
      pend_tgt_q <= pend_tgt_d;
      pend_q     <= pend_d;
    end
  end

  assign pc_o   = pc_q;
  assign pend_o = pend_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: boot delay, prediction, pending slot,
// flush, wrap-around and mid-run reset.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rstn;
  logic        hold_i;
  logic        flush_en_i;
  logic [31:0] flush_base_i;
  logic [31:0] flush_ofset_i;
  logic        prd_en_i;
  logic [31:0] prd_base_i;
  logic [31:0] prd_ofset_i;
  logic        fetch_ready_i;
  logic        fetch_valid_o;
  logic [31:0] pc_o;
  logic        pend_o;

  int n_vec = 0;
  int n_err = 0;

  pc_gen dut (
    .clk           (clk),
    .rstn          (rstn),
    .hold_i        (hold_i),
    .flush_en_i    (flush_en_i),
    .flush_base_i  (flush_base_i),
    .flush_ofset_i (flush_ofset_i),
    .prd_en_i      (prd_en_i),
    .prd_base_i    (prd_base_i),
    .prd_ofset_i   (prd_ofset_i),
    .fetch_ready_i (fetch_ready_i),
    .fetch_valid_o (fetch_valid_o),
    .pc_o          (pc_o),
    .pend_o        (pend_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic flush(input logic [31:0] b, input logic [31:0] o);
    flush_en_i = 1'b1; flush_base_i = b; flush_ofset_i = o;
    step();
    flush_en_i = 1'b0;
  endtask

  task automatic prd(input logic en, input logic [31:0] b,
                     input logic [31:0] o);
    prd_en_i = en; prd_base_i = b; prd_ofset_i = o;
  endtask

  initial begin
    rstn = 1'b0; hold_i = 1'b0; flush_en_i = 1'b0;
    flush_base_i = '0; flush_ofset_i = '0;
    prd_en_i = 1'b0; prd_base_i = '0; prd_ofset_i = '0;
    fetch_ready_i = 1'b1;
    step(); step();
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_valid", fetch_valid_o, 0);
    chk("rst_pend", pend_o, 0);

    // boot: two cycles without valid, prediction ignored
    rstn = 1'b1;
    prd(1'b1, 32'h40, 32'h0);
    #1 chk("boot0_valid", fetch_valid_o, 0);
    step();
    chk("boot1_valid", fetch_valid_o, 0);
    chk("boot_prd_pend", pend_o, 0);
    chk("boot_prd_pc", pc_o, 32'h0);
    prd(1'b0, 0, 0);
    step();
    chk("run_valid", fetch_valid_o, 1);
    chk("seq0", pc_o, 32'h0);
    step(); chk("seq1", pc_o, 32'h4);
    step(); chk("seq2", pc_o, 32'h8);

    // taken prediction on handshake
    flush(32'h10, 32'h0);
    chk("flush10", pc_o, 32'h10);
    prd(1'b1, 32'h100, 32'h20);
    step();
    chk("prd_hs_pc", pc_o, 32'h120);
    chk("prd_hs_pend", pend_o, 0);
    prd(1'b0, 0, 0);

    // late prediction goes to the pending slot
    flush(32'h10, 32'h0);
    fetch_ready_i = 1'b0;
    prd(1'b1, 32'h200, 32'h0);
    step();
    chk("pend_set", pend_o, 1);
    chk("pend_hold_pc", pc_o, 32'h10);
    prd(1'b0, 0, 0);
    step();
    chk("stall_pc", pc_o, 32'h10);
    fetch_ready_i = 1'b1;
    step();
    chk("pend_use_pc", pc_o, 32'h200);
    chk("pend_use_clr", pend_o, 0);

    // newer prediction overwrites pending one
    fetch_ready_i = 1'b0;
    prd(1'b1, 32'h300, 32'h0); step();
    prd(1'b1, 32'h340, 32'h4); step();
    prd(1'b0, 0, 0);
    fetch_ready_i = 1'b1;
    step();
    chk("pend_newer", pc_o, 32'h344);

    // flush under hold with pending slot full
    fetch_ready_i = 1'b0;
    prd(1'b1, 32'h300, 32'h0); step();
    prd(1'b0, 0, 0);
    chk("pend_pre_flush", pend_o, 1);
    hold_i = 1'b1;
    fetch_ready_i = 1'b1;
    #1 chk("hold_valid", fetch_valid_o, 0);
    flush(32'h80, 32'h6);
    chk("flush_mask_pc", pc_o, 32'h84);
    chk("flush_pend_clr", pend_o, 0);
    step();
    chk("hold_pc", pc_o, 32'h84);
    hold_i = 1'b0;
    step();
    chk("after_hold_seq", pc_o, 32'h88);

    // stale pending slot is overridden by a live prediction
    fetch_ready_i = 1'b0;
    prd(1'b1, 32'h400, 32'h0); step();
    fetch_ready_i = 1'b1;
    prd(1'b1, 32'h500, 32'h0); step();
    chk("live_over_pend", pc_o, 32'h500);
    chk("live_pend_clr", pend_o, 0);
    prd(1'b0, 0, 0);
    step();
    chk("live_then_seq", pc_o, 32'h504);

    // address wrap
    flush(32'hFFFF_FFF0, 32'hC);
    chk("near_top", pc_o, 32'hFFFF_FFFC);
    step();
    chk("seq_wrap", pc_o, 32'h0);
    flush(32'hFFFF_FFF0, 32'h20);
    chk("flush_wrap", pc_o, 32'h10);

    // reset mid-run with a pending target
    fetch_ready_i = 1'b0;
    prd(1'b1, 32'h600, 32'h0); step();
    prd(1'b0, 0, 0);
    chk("pend_pre_rst", pend_o, 1);
    rstn = 1'b0;
    #1;
    chk("mid_rst_pc", pc_o, 32'h0);
    chk("mid_rst_pend", pend_o, 0);
    chk("mid_rst_valid", fetch_valid_o, 0);
    step();
    rstn = 1'b1;
    fetch_ready_i = 1'b1;
    step();
    chk("reboot_valid", fetch_valid_o, 0);
    step();
    chk("reboot_run", fetch_valid_o, 1);
    chk("reboot_pc", pc_o, 32'h0);
    step();
    chk("reboot_seq", pc_o, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
